shift_reg_n: RTL and testbench

SHIFT_REG_N -- requirements
Module: shift_reg_n

---
 rtl/shift_reg_n.sv | 109 ++++++++++
 tb/tb_shift_reg_n.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_n.sv
// shift_reg_n: WIDTH-bit universal shift register with hold, load, shift and rotate modes.
// Optional serial burst (parallel load, then shift out LSB first) when SHIFT_REG_BURST_EN is defined.
module shift_reg_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             SI,
    input  logic [WIDTH-1:0] D,
    input  logic [2:0]       M,
    output logic [WIDTH-1:0] Q,
    output logic             SO,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_ROL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_SHL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_ASR   = 3'b110,
        MODE_BURST = 3'b111
    } mode_t;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_idle_q;
    mode_t            w_mode;

    assign w_mode = mode_t'(M);

    // Next register value for an idle edge; burst start falls back to hold here.
    always_comb begin
        w_idle_q = r_q;
        unique case (w_mode)
            MODE_HOLD:  w_idle_q = r_q;
            MODE_LOAD:  w_idle_q = D;
            MODE_ROL:   w_idle_q = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            MODE_SHR:   w_idle_q = {SI, r_q[WIDTH-1:1]};
            MODE_SHL:   w_idle_q = {r_q[WIDTH-2:0], SI};
            MODE_ROR:   w_idle_q = {r_q[0], r_q[WIDTH-1:1]};
            MODE_ASR:   w_idle_q = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            MODE_BURST: w_idle_q = r_q;
        endcase
    end

`ifdef SHIFT_REG_BURST_EN

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic          w_last;

    assign w_last = (r_cnt == LAST);

    // Register update: burst shifting takes priority over mode decode while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_q    <= {SI, r_q[WIDTH-1:1]};
            r_done <= w_last;
            if (w_last) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else if (w_mode == MODE_BURST) begin
            r_q    <= D;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else begin
            r_q    <= w_idle_q;
            r_done <= 1'b0;
        end
    end

    assign busy = r_busy;
    assign done = r_done;

`else

    // Register update: plain mode decode, burst code behaves as hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= w_idle_q;
        end
    end

    assign busy = 1'b0;
    assign done = 1'b0;

`endif

    assign Q  = r_q;
    assign SO = r_q[0];

endmodule

// File: tb/tb_shift_reg_n.sv
// tb_shift_reg_n: scoreboard bench for shift_reg_n at WIDTH=4 and WIDTH=8.
// Expectations come from a behavioural model and fixed vectors.
module tb_shift_reg_n;

    logic       clk = 1'b0;
    logic       reset;
    logic       SI;
    logic [2:0] M;
    logic [3:0] D4;
    logic [7:0] D8;
    logic [3:0] Q4;
    logic [7:0] Q8;
    logic       SO4, SO8, busy4, busy8, done4, done8;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] q;
        logic        busy;
        logic        done;
        int          cnt;
    } mstate_t;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] v;
    } exp_t;

    mstate_t s4, s8;
    exp_t    sb[$];

    shift_reg_n #(.WIDTH(4)) u4 (
        .clk(clk), .reset(reset), .SI(SI), .D(D4), .M(M),
        .Q(Q4), .SO(SO4), .busy(busy4), .done(done4)
    );

    shift_reg_n #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .SI(SI), .D(D8), .M(M),
        .Q(Q8), .SO(SO8), .busy(busy8), .done(done8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic mstate_t nstate(input int w, input mstate_t s, input logic rst,
                                       input logic [2:0] m, input logic [31:0] d,
                                       input logic si);
        mstate_t     n = s;
        logic [31:0] mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        n.done = 1'b0;
        if (rst) begin
            n.q = '0; n.busy = 1'b0; n.cnt = 0;
            return n;
        end
`ifdef SHIFT_REG_BURST_EN
        if (s.busy) begin
            n.q = (s.q >> 1) | (32'(si) << (w - 1));
            if (s.cnt == w - 1) begin
                n.busy = 1'b0; n.done = 1'b1;
            end else begin
                n.cnt = s.cnt + 1;
            end
            return n;
        end
        if (m == 3'b111) begin
            n.q = d & mask; n.busy = 1'b1; n.cnt = 0;
            return n;
        end
`endif
        case (m)
            3'b001: n.q = d;
            3'b010: n.q = (s.q << 1) | (s.q >> (w - 1));
            3'b011: n.q = (s.q >> 1) | (32'(si) << (w - 1));
            3'b100: n.q = (s.q << 1) | 32'(si);
            3'b101: n.q = (s.q >> 1) | (32'(s.q[0]) << (w - 1));
            3'b110: n.q = (s.q >> 1) | (32'(s.q[w-1]) << (w - 1));
            default: n.q = s.q;
        endcase
        n.q = n.q & mask;
        return n;
    endfunction

    function automatic logic [31:0] obs(input int sig);
        case (sig)
            0: return 32'(Q4);
            1: return 32'(busy4);
            2: return 32'(done4);
            3: return 32'(SO4);
            4: return 32'(Q8);
            5: return 32'(busy8);
            6: return 32'(done8);
            default: return 32'(SO8);
        endcase
    endfunction

    task automatic push(input string t, input int sig, input logic [31:0] v);
        exp_t e;
        e.tag = t; e.sig = sig; e.v = v;
        sb.push_back(e);
    endtask

    task automatic tick(input logic rst, input logic [2:0] m, input logic [3:0] d4v,
                        input logic [7:0] d8v, input logic si);
        exp_t e;
        reset = rst; M = m; D4 = d4v; D8 = d8v; SI = si;
        s4 = nstate(4, s4, rst, m, 32'(d4v), si);
        s8 = nstate(8, s8, rst, m, 32'(d8v), si);
        push("q4", 0, s4.q);
        push("busy4", 1, 32'(s4.busy));
        push("done4", 2, 32'(s4.done));
        push("so4", 3, 32'(s4.q[0]));
        push("q8", 4, s8.q);
        push("busy8", 5, 32'(s8.busy));
        push("done8", 6, 32'(s8.done));
        push("so8", 7, 32'(s8.q[0]));
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.sig), e.v);
        end
    endtask

    initial begin
        logic [3:0] so_seq;
        int         bcnt, dcnt, lowcnt, stray, last;
        logic       burst_on;
`ifdef SHIFT_REG_BURST_EN
        burst_on = 1'b1;
`else
        burst_on = 1'b0;
`endif
        s4 = '{q: '0, busy: 1'b0, done: 1'b0, cnt: 0};
        s8 = '{q: '0, busy: 1'b0, done: 1'b0, cnt: 0};
        reset = 1'b0; M = 3'b000; D4 = '0; D8 = '0; SI = 1'b0;

        tick(1, 3'b000, 4'h0, 8'h00, 0);
        chk("rst_q", 32'(Q4), 32'h0);
        chk("rst_busy", 32'(busy4), 32'h0);
        tick(0, 3'b001, 4'b1101, 8'hA5, 0);
        chk("load", 32'(Q4), 32'hD);
        tick(0, 3'b000, 4'b0000, 8'h00, 1);
        chk("hold", 32'(Q4), 32'hD);
        tick(0, 3'b011, 4'b0000, 8'h00, 0);
        chk("shr_si0", 32'(Q4), 32'h6);
        tick(0, 3'b011, 4'b0000, 8'h00, 1);
        chk("shr_si1", 32'(Q4), 32'hB);
        tick(0, 3'b010, 4'b0000, 8'h00, 0);
        chk("rol", 32'(Q4), 32'h7);
        tick(0, 3'b101, 4'b0000, 8'h00, 0);
        chk("ror", 32'(Q4), 32'hB);
        tick(0, 3'b110, 4'b0000, 8'h00, 0);
        chk("asr1", 32'(Q4), 32'hD);
        tick(0, 3'b110, 4'b0000, 8'h00, 1);
        chk("asr2", 32'(Q4), 32'hE);
        tick(0, 3'b100, 4'b0000, 8'h00, 1);
        chk("shl_si1", 32'(Q4), 32'hD);

        tick(0, 3'b111, 4'b1001, 8'h3C, 0);
        so_seq = '0;
        bcnt = 0;
        for (int i = 0; i < 4; i++) begin
            so_seq[i] = SO4;
            bcnt += int'(busy4);
            tick(0, 3'b000, 4'b0000, 8'h00, 0);
        end
        chk("burst_so", 32'(so_seq), burst_on ? 32'h9 : 32'hF);
        chk("burst_busy", 32'(bcnt), burst_on ? 32'd4 : 32'd0);
        chk("burst_done", 32'(done4), 32'(burst_on));
        chk("burst_q", 32'(Q4), burst_on ? 32'h0 : 32'hD);
        tick(0, 3'b000, 4'b0000, 8'h00, 0);
        chk("done_once", 32'(done4), 32'h0);

        tick(0, 3'b111, 4'b1010, 8'h5A, 1);
        tick(0, 3'b000, 4'b0000, 8'h00, 1);
        tick(0, 3'b001, 4'b1111, 8'hFF, 1);
        chk("m_ignored", 32'(Q4), burst_on ? 32'hE : 32'hF);
        tick(1, 3'b000, 4'b0000, 8'h00, 1);
        chk("abort_q", 32'(Q4), 32'h0);
        chk("abort_done", 32'(done4), 32'h0);
        tick(0, 3'b000, 4'b0000, 8'h00, 0);
        chk("abort_idle", 32'(busy4), 32'h0);

        tick(1, 3'b000, 4'b0000, 8'h00, 0);
        tick(0, 3'b111, 4'b0110, 8'hC3, 0);
        dcnt = 0; lowcnt = 0; stray = 0; last = -1;
        for (int i = 1; i <= 27; i++) begin
            tick(0, 3'b111, 4'b0110, 8'hC3, 1'($urandom_range(0, 1)));
            if (!busy8) lowcnt++;
            if (!busy8 && !done8) stray++;
            if (done8) begin
                if (last >= 0) chk("b2b_gap", 32'(i - last), 32'd9);
                last = i;
                dcnt++;
            end
        end
        chk("b2b_done", 32'(dcnt), burst_on ? 32'd3 : 32'd0);
        chk("b2b_low", 32'(lowcnt), burst_on ? 32'd3 : 32'd27);
        chk("b2b_stray", 32'(stray), burst_on ? 32'd0 : 32'd27);
        chk("b2b_q8", 32'(Q8), burst_on ? 32'(s8.q) : 32'h0);

        for (int i = 0; i < 60; i++) begin
            tick(1'($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)),
                 4'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
